mux: RTL and testbench
======================

// Module: mux
// PURPOSE
//  2:1 datapath selector for the CPU: forwards operand a or b to out under sel.
//  Primary path is purely combinational, so out follows inputs within the same delta.
//  Also provides a registered copy of the result, the registered select and a
//  select-change strobe, so pipeline stages and debug logic can sample a stable value.
// PARAMETERS
//  WIDTH  1  data width of a, b, out, out_q (>=1)
// PORTS
//  clk      in   1      rising-edge clock for the registered outputs
//  rst      in   1      asynchronous, active-high reset
//  a        in   WIDTH  data input selected when sel=0
//  b        in   WIDTH  data input selected when sel=1
//  sel      in   1      select: 0 -> a, 1 -> b
//  out      out  WIDTH  combinational result: sel ? b : a
//  out_q    out  WIDTH  out registered on clk
//  sel_q    out  1      sel registered on clk
//  switched out  1      registered strobe: 1 for one cycle after sel differs from sel_q
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-high (rst), applied
//    immediately on assertion and released synchronously to clk.
//  - out = (sel == 1'b1) ? b : a. Zero latency, no clock/reset dependence.
//    out is valid even if clk never toggles and rst is never asserted.
//  - Full truth table (WIDTH=1), a b sel -> out:
//    000->0 001->0 010->0 011->1 100->1 101->0 110->1 111->1
//  - sel=X/Z: out = a where a==b bitwise, else X (plain ternary semantics).
//  - Reset values: out_q=0, sel_q=0, switched=0; out is not reset (combinational).
//  - Each rising clk edge with rst=0: out_q <= out; sel_q <= sel;
//    switched <= (sel != sel_q). Latency 1 cycle for all registered outputs.
//  - First edge after reset with sel=1: switched=1 (sel_q resets to 0).
//  - Simultaneous change of a/b and sel before an edge: out_q captures the
//    post-change combinational value; no glitch filtering.
//  - rst asserted mid-operation: registered outputs clear at once; out keeps
//    tracking inputs.
// STRUCTURE
//  - Shared package mux_pkg: localparams SEL_A = 1'b0, SEL_B = 1'b1;
//    default WIDTH constant for datapath operands.
//  - One sub-module: mux_out_reg (WIDTH-wide async-reset register holding
//    out_q, sel_q, switched). Select logic stays in the top module.
// TESTING
//  - No clock driven, rst=0: sweep all 8 (a,b,sel) combinations, 10 ns apart
//    -> out matches the truth table above at every step.
//  - a=0,b=1: sel 0 -> 1 -> out 0 -> 1 within the same time step (no clock).
//  - rst=1 pulse at any time -> out_q=0, sel_q=0, switched=0 immediately,
//    without a clock edge.
//  - After reset: a=1,b=0,sel=0, one clk edge -> out_q=1, switched=0; set sel=1,
//    one edge -> out_q=0, sel_q=1, switched=1; next edge -> switched=0.
//  - WIDTH=8: a=8'hA5, b=8'h3C -> out=8'hA5 (sel=0), 8'h3C (sel=1).
//  - Assert rst between edges while sel toggles -> registered outputs are 0 and
//    out still equals sel ? b : a.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the 2:1 datapath selector.
package mux_pkg;

   // Select encodings: which operand is forwarded
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // Default operand width for datapath users
   localparam int unsigned DefaultWidth = 1;

endpackage

// File: rtl/mux_if.sv
// Operand/result bundle for the 2:1 selector.
interface mux_if
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sel;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_q;
   logic             sel_q;
   logic             switched;

   // Producer of operands/select, consumer of results
   modport master (
      output a, b, sel,
      input  out, out_q, sel_q, switched
   );

   // The selector itself
   modport slave (
      input  a, b, sel,
      output out, out_q, sel_q, switched
   );

endinterface

// File: rtl/mux_out_reg.sv
// Registered copy of the selector result, the select and a select-change strobe.
module mux_out_reg
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] out_i,
   input  logic             sel_i,
   output logic [WIDTH-1:0] out_q_o,
   output logic             sel_q_o,
   output logic             switched_o
);

   logic [WIDTH-1:0] data_d, data_q;
   logic             sel_d, sel_q;
   logic             switched_d, switched_q;

   // Next state: capture result and select, flag a select change vs. last cycle
   always_comb begin
      data_d     = out_i;
      sel_d      = sel_i;
      switched_d = (sel_i != sel_q);
   end

   // State: async active-high reset clears everything immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q     <= '0;
         sel_q      <= SEL_A;
         switched_q <= 1'b0;
      end else begin
         data_q     <= data_d;
         sel_q      <= sel_d;
         switched_q <= switched_d;
      end
   end

   assign out_q_o    = data_q;
   assign sel_q_o    = sel_q;
   assign switched_o = switched_q;

endmodule

// File: rtl/mux.sv
// 2:1 datapath selector: combinational out plus registered copies for pipelines/debug.
module mux
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic  clk,
   input  logic  rst,
   mux_if.slave  bus
);

   logic [WIDTH-1:0] out_sel;

   // Select path: plain ternary so an unknown select merges a and b bitwise
   always_comb begin
      out_sel = (bus.sel == SEL_B) ? bus.b : bus.a;
   end

   assign bus.out = out_sel;

   mux_out_reg #(
      .WIDTH (WIDTH)
   ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .out_i      (out_sel),
      .sel_i      (bus.sel),
      .out_q_o    (bus.out_q),
      .sel_q_o    (bus.sel_q),
      .switched_o (bus.switched)
   );

endmodule

// File: tb/tb_mux.sv
// Scoreboard bench for mux: a 1-bit and an 8-bit instance share clock and reset.
module tb_mux;

   logic clk;
   logic rst;
   logic clk_en;

   mux_if #(.WIDTH(1)) if1 ();
   mux_if #(.WIDTH(8)) if8 ();

   mux #(.WIDTH(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   mux #(.WIDTH(8)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (if8)
   );

   // Gated free-running clock, 10 ns period
   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   typedef enum logic [2:0] {
      ObsOut1, ObsOutQ1, ObsSelQ1, ObsSw1,
      ObsOut8, ObsOutQ8, ObsSelQ8, ObsSw8
   } obs_e;

   typedef struct {
      string      tag;
      obs_e       kind;
      logic [7:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks;
   int   n_errors;

   function automatic logic [7:0] observe(input obs_e kind);
      case (kind)
         ObsOut1:  return {7'd0, if1.out};
         ObsOutQ1: return {7'd0, if1.out_q};
         ObsSelQ1: return {7'd0, if1.sel_q};
         ObsSw1:   return {7'd0, if1.switched};
         ObsOut8:  return if8.out;
         ObsOutQ8: return if8.out_q;
         ObsSelQ8: return {7'd0, if8.sel_q};
         default:  return {7'd0, if8.switched};
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_exp(input string tag, input obs_e kind, input logic [7:0] exp);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.exp  = exp;
      exp_q.push_back(e);
   endtask

   task automatic drain_exp();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq(e.tag, observe(e.kind), e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_regs(input string tag, input logic [7:0] oq1, input logic sq1,
                              input logic sw1, input logic [7:0] oq8, input logic sq8,
                              input logic sw8);
      push_exp({tag, ".out_q1"}, ObsOutQ1, oq1);
      push_exp({tag, ".sel_q1"}, ObsSelQ1, {7'd0, sq1});
      push_exp({tag, ".sw1"},    ObsSw1,   {7'd0, sw1});
      push_exp({tag, ".out_q8"}, ObsOutQ8, oq8);
      push_exp({tag, ".sel_q8"}, ObsSelQ8, {7'd0, sq8});
      push_exp({tag, ".sw8"},    ObsSw8,   {7'd0, sw8});
   endtask

   // Hard bound on total run time
   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] tt;
      time        t0;
      n_checks = 0;
      n_errors = 0;
      clk_en   = 1'b0;
      rst      = 1'b0;
      tt       = 8'b1101_1000; // out for index {a,b,sel}
      if8.a    = 8'hA5;
      if8.b    = 8'h3C;
      if8.sel  = 1'b0;

      // Combinational sweep, no clock, no reset
      for (int i = 0; i < 8; i++) begin
         {if1.a, if1.b, if1.sel} = 3'(i);
         push_exp($sformatf("tt%0d", i), ObsOut1, {7'd0, tt[i]});
         #1;
         drain_exp();
         #9;
      end

      // 8-bit operands, both selects
      if8.sel = 1'b0;
      push_exp("w8.sel0", ObsOut8, 8'hA5);
      #1;
      drain_exp();
      if8.sel = 1'b1;
      push_exp("w8.sel1", ObsOut8, 8'h3C);
      #1;
      drain_exp();

      // Select flip seen in the same time step
      if1.a   = 1'b0;
      if1.b   = 1'b1;
      if1.sel = 1'b0;
      #1;
      push_exp("flip.before", ObsOut1, 8'h00);
      drain_exp();
      t0      = $time;
      if1.sel = 1'b1;
      fork
         wait (if1.out === 1'b1);
         #1;
      join_any
      disable fork;
      push_exp("flip.after", ObsOut1, 8'h01);
      drain_exp();
      check_eq("flip.same_step", ($time == t0) ? 8'h01 : 8'h00, 8'h01);

      // Reset pulse with no clock running
      rst = 1'b1;
      #1;
      expect_regs("rst0", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      drain_exp();

      // Start the clock, release reset away from the rising edge
      clk_en = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      if1.a   = 1'b1;
      if1.b   = 1'b0;
      if1.sel = 1'b0;
      if8.a   = 8'hA5;
      if8.b   = 8'h3C;
      if8.sel = 1'b0;
      tick();
      expect_regs("e1", 8'h01, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
      drain_exp();

      if1.sel = 1'b1;
      if8.sel = 1'b1;
      push_exp("e2.out8", ObsOut8, 8'h3C);
      tick();
      expect_regs("e2", 8'h00, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
      drain_exp();

      tick();
      expect_regs("e3", 8'h00, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
      drain_exp();

      // Operands and select change together before the edge
      if1.a   = 1'b1;
      if1.b   = 1'b1;
      if1.sel = 1'b0;
      if8.a   = 8'h11;
      if8.b   = 8'h22;
      if8.sel = 1'b0;
      tick();
      expect_regs("e4", 8'h01, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
      drain_exp();

      if1.sel = 1'b1;
      if8.sel = 1'b1;
      tick();
      expect_regs("e5", 8'h01, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
      drain_exp();

      // Mid-cycle reset: registers clear at once, out keeps tracking
      rst = 1'b1;
      #1;
      expect_regs("rst1", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      drain_exp();
      if8.sel = 1'b0;
      #1;
      push_exp("rst1.out8", ObsOut8, 8'h11);
      drain_exp();
      tick();
      expect_regs("rst1.held", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      push_exp("rst1.held.out8", ObsOut8, 8'h11);
      drain_exp();
      if8.sel = 1'b1;
      #1;
      push_exp("rst1.out8b", ObsOut8, 8'h22);
      drain_exp();

      // First edge after reset with sel=1 raises switched
      @(negedge clk);
      rst = 1'b0;
      tick();
      expect_regs("e6", 8'h01, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
      drain_exp();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
